// File: rtl/compuertas_pkg.sv
// rtl/compuertas_pkg.sv - shared constants and state encoding for the compuertas self-test sequencer
package compuertas_pkg;
    localparam int NUM_COMBOS = 8;
    localparam int IDX_W      = 3;

    typedef logic [2:0] state_t;
    localparam state_t IDLE    = 3'd0;
    localparam state_t APPLY   = 3'd1;
    localparam state_t SETTLE  = 3'd2;
    localparam state_t CAPTURE = 3'd3;
    localparam state_t DONE    = 3'd4;

    // Truth tables of the gate block: S1 = A&B&C, S2 = A|B|C, bit i = combo i
    localparam logic [NUM_COMBOS-1:0] DEF_EXP_S1 = 8'h80;
    localparam logic [NUM_COMBOS-1:0] DEF_EXP_S2 = 8'hFE;
endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter timing the settle wait after each applied combo
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);
    localparam int W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    // Loaded with N-1 so the last of N settle cycles is the one that sees zero
    localparam logic [W-1:0] LOAD_VAL = (SETTLE_CYCLES == 0) ? W'(0) : W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/compuertas_sequencer.sv
// rtl/compuertas_sequencer.sv - sweeps all A/B/C combos into compuertas and checks S1/S2
module compuertas_sequencer
    import compuertas_pkg::*;
#(
    parameter int                    SETTLE_CYCLES = 2,
    parameter logic [NUM_COMBOS-1:0] EXP_S1        = DEF_EXP_S1,
    parameter logic [NUM_COMBOS-1:0] EXP_S2        = DEF_EXP_S2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s1_in,
    input  logic                  s2_in,
    output logic                  a_out,
    output logic                  b_out,
    output logic                  c_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [3:0]            err_count,
    output logic [IDX_W-1:0]      fail_idx,
    output logic [NUM_COMBOS-1:0] res_s1,
    output logic [NUM_COMBOS-1:0] res_s2
);
    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic             timer_load;
    logic             timer_expired;
    logic             mismatch;

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = APPLY;
            APPLY:   next_state = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
            SETTLE:  if (timer_expired) next_state = CAPTURE;
            CAPTURE: next_state = (idx == IDX_W'(NUM_COMBOS - 1)) ? DONE : APPLY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // Abort overrides everything, including a start seen in IDLE
        if (abort) next_state = IDLE;
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        timer_load = 1'b0;
        case (state)
            APPLY: begin
                busy       = 1'b1;
                timer_load = 1'b1;
            end
            SETTLE, CAPTURE: busy = 1'b1;
            DONE:            done = 1'b1;
            default:         ;
        endcase
        {a_out, b_out, c_out} = busy ? idx : 3'd0;
    end

    assign mismatch = (s1_in != EXP_S1[idx]) || (s2_in != EXP_S2[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_idx  <= '0;
            res_s1    <= '0;
            res_s2    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx       <= '0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_idx  <= '0;
                        res_s1    <= '0;
                        res_s2    <= '0;
                    end
                end
                CAPTURE: begin
                    if (!abort) begin
                        res_s1[idx] <= s1_in;
                        res_s2[idx] <= s2_in;
                        if (mismatch) begin
                            if (err_count == 4'd0) fail_idx <= idx;
                            if (err_count != 4'(NUM_COMBOS)) err_count <= err_count + 4'd1;
                        end
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE:    pass <= (err_count == 4'd0);
                default: ;
            endcase
            if (abort && state != IDLE) pass <= 1'b0;
        end
    end
endmodule

// File: tb/tb_compuertas_sequencer.sv
// tb/tb_compuertas_sequencer.sv - scoreboard bench for compuertas_sequencer sweeps, abort and reset
module tb_compuertas_sequencer;
    logic clk = 1'b0;
    logic rst, start, abort, stuck;
    always #5 clk = ~clk;

    logic       a, b, c, busy, done, pass, s1, s2;
    logic [3:0] err;
    logic [2:0] fidx;
    logic [7:0] rs1, rs2;

    logic       a0, b0, c0, busy0, done0, pass0, s1z, s2z;
    logic [3:0] err0;
    logic [2:0] fidx0;
    logic [7:0] rs1_0, rs2_0;

    // Gate block models; stuck forces S1 high on the default-settle instance
    assign s1  = stuck | (a & b & c);
    assign s2  = a | b | c;
    assign s1z = a0 & b0 & c0;
    assign s2z = a0 | b0 | c0;

    compuertas_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .s1_in(s1), .s2_in(s2),
        .a_out(a), .b_out(b), .c_out(c), .busy(busy), .done(done), .pass(pass),
        .err_count(err), .fail_idx(fidx), .res_s1(rs1), .res_s2(rs2)
    );

    compuertas_sequencer #(.SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .s1_in(s1z), .s2_in(s2z),
        .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_idx(fidx0), .res_s1(rs1_0), .res_s2(rs2_0)
    );

    typedef struct {
        logic [7:0] s1;
        logic [7:0] s2;
        logic [3:0] err;
        logic [2:0] fidx;
        logic       pass;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t model(input logic stk);
        exp_t       e;
        logic [7:0] tbl_s1;
        logic [7:0] tbl_s2;
        logic       g1, g2;
        tbl_s1 = 8'h80;
        tbl_s2 = 8'hFE;
        e.s1 = '0; e.s2 = '0; e.err = '0; e.fidx = '0;
        for (int i = 0; i < 8; i++) begin
            g1 = stk | (i == 7);
            g2 = (i != 0);
            e.s1[i] = g1;
            e.s2[i] = g2;
            if (g1 != tbl_s1[i] || g2 != tbl_s2[i]) begin
                if (e.err == 0) e.fidx = 3'(i);
                e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic drive_sweep(input bit repulse, input int abort_combo, input int rst_combo,
                               output int done_edge, output int done_cnt, output int restarts);
        int         seen_abort;
        bit         p2, p5;
        logic [2:0] abc;
        done_edge = -1; done_cnt = 0; restarts = 0; seen_abort = 0; p2 = 0; p5 = 0;
        if (abort_combo < 0 && rst_combo < 0) sb.push_back(model(stuck));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int t = 0; t < 40; t++) begin
            abc = {a, b, c};
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = t;
            end else if (done_edge >= 0 && busy) begin
                restarts++;
            end
            start = 1'b0;
            if (repulse && busy && !p2 && abc == 3'd2) begin start = 1'b1; p2 = 1; end
            if (repulse && busy && !p5 && abc == 3'd5) begin start = 1'b1; p5 = 1; end
            if (busy && abort_combo >= 0 && int'(abc) == abort_combo) begin
                seen_abort++;
                if (seen_abort == 2) begin
                    abort = 1'b1;
                    @(negedge clk) abort = 1'b0;
                    return;
                end
            end
            if (busy && rst_combo >= 0 && int'(abc) == rst_combo) begin
                rst = 1'b1;
                @(negedge clk) rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_results(input string tag);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            n_checks++; if (rs1 !== e.s1)   begin n_fail++; $display("FAIL %s res_s1 got %h exp %h", tag, rs1, e.s1); end
            n_checks++; if (rs2 !== e.s2)   begin n_fail++; $display("FAIL %s res_s2 got %h exp %h", tag, rs2, e.s2); end
            n_checks++; if (err !== e.err)  begin n_fail++; $display("FAIL %s err_count got %0d exp %0d", tag, err, e.err); end
            n_checks++; if (fidx !== e.fidx) begin n_fail++; $display("FAIL %s fail_idx got %0d exp %0d", tag, fidx, e.fidx); end
            n_checks++; if (pass !== e.pass) begin n_fail++; $display("FAIL %s pass got %b exp %b", tag, pass, e.pass); end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++; if ({a, b, c} !== 3'b0)  begin n_fail++; $display("FAIL %s abc got %b exp 000", tag, {a, b, c}); end
        n_checks++; if ({busy, done, pass} !== 3'b0) begin n_fail++; $display("FAIL %s busy/done/pass got %b exp 000", tag, {busy, done, pass}); end
        n_checks++; if ({err, fidx} !== 7'b0) begin n_fail++; $display("FAIL %s err/fidx got %0d/%0d exp 0/0", tag, err, fidx); end
        n_checks++; if ({rs1, rs2} !== 16'b0) begin n_fail++; $display("FAIL %s res got %h/%h exp 00/00", tag, rs1, rs2); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; stuck = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_sweep();
        int de, dc, rs;
        drive_sweep(0, -1, -1, de, dc, rs);
        n_checks++; if (de !== 32) begin n_fail++; $display("FAIL good_done_edge got %0d exp 32", de); end
        n_checks++; if (dc !== 1)  begin n_fail++; $display("FAIL good_done_count got %0d exp 1", dc); end
        check_results("good");
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        repeat (2) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle busy got %b exp 0", busy); end
            @(negedge clk);
        end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL start_abort_idle pass got %b exp 1", pass); end
    endtask

    task automatic test_stuck_s1();
        int de, dc, rs;
        stuck = 1'b1;
        drive_sweep(0, -1, -1, de, dc, rs);
        n_checks++; if (de !== 32) begin n_fail++; $display("FAIL stuck_done_edge got %0d exp 32", de); end
        check_results("stuck");
        stuck = 1'b0;
    endtask

    task automatic test_settle_zero();
        logic [2:0] exp_abc[$];
        int         de;
        de = -1;
        for (int i = 0; i < 8; i++) begin
            exp_abc.push_back(3'(i));
            exp_abc.push_back(3'(i));
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (busy0) begin
                n_checks++;
                if (exp_abc.size() == 0) begin
                    n_fail++; $display("FAIL settle0_abc extra busy cycle t=%0d abc %b", t, {a0, b0, c0});
                end else if ({a0, b0, c0} !== exp_abc[0]) begin
                    n_fail++; $display("FAIL settle0_abc t=%0d got %b exp %b", t, {a0, b0, c0}, exp_abc[0]);
                    void'(exp_abc.pop_front());
                end else begin
                    void'(exp_abc.pop_front());
                end
            end
            if (done0 && de < 0) de = t;
            @(negedge clk);
        end
        n_checks++; if (de !== 16) begin n_fail++; $display("FAIL settle0_done_edge got %0d exp 16", de); end
        n_checks++; if (exp_abc.size() !== 0) begin n_fail++; $display("FAIL settle0_steps missing got %0d exp 0", exp_abc.size()); end
        n_checks++; if ({pass0, err0, rs1_0, rs2_0} !== {1'b1, 4'd0, 8'h80, 8'hFE})
            begin n_fail++; $display("FAIL settle0_result got %b/%0d/%h/%h exp 1/0/80/fe", pass0, err0, rs1_0, rs2_0); end
    endtask

    task automatic test_back_to_back();
        int de, dc, rs;
        drive_sweep(1, -1, -1, de, dc, rs);
        n_checks++; if (de !== 32) begin n_fail++; $display("FAIL repulse_done_edge got %0d exp 32", de); end
        n_checks++; if (dc !== 1)  begin n_fail++; $display("FAIL repulse_done_count got %0d exp 1", dc); end
        n_checks++; if (rs !== 0)  begin n_fail++; $display("FAIL repulse_restart got %0d exp 0", rs); end
        check_results("repulse");
    endtask

    task automatic test_abort();
        int de, dc, rs, late_done;
        stuck = 1'b1;
        drive_sweep(0, 4, -1, de, dc, rs);
        n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got %b exp 000", {busy, done, pass}); end
        n_checks++; if (rs1 !== 8'h0F) begin n_fail++; $display("FAIL abort_res_s1 got %h exp 0f", rs1); end
        n_checks++; if (rs2 !== 8'h0E) begin n_fail++; $display("FAIL abort_res_s2 got %h exp 0e", rs2); end
        n_checks++; if ({err, fidx} !== {4'd4, 3'd0}) begin n_fail++; $display("FAIL abort_err got %0d/%0d exp 4/0", err, fidx); end
        late_done = 0;
        repeat (40) begin
            if (done) late_done++;
            @(negedge clk);
        end
        n_checks++; if (late_done !== 0) begin n_fail++; $display("FAIL abort_done_pulses got %0d exp 0", late_done); end
        stuck = 1'b0;
    endtask

    task automatic test_rst_mid();
        int de, dc, rs;
        drive_sweep(0, -1, 3, de, dc, rs);
        check_all_zero("rst_mid");
        drive_sweep(0, -1, -1, de, dc, rs);
        n_checks++; if (de !== 32) begin n_fail++; $display("FAIL rst_resweep_done_edge got %0d exp 32", de); end
        check_results("rst_resweep");
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_start_abort_idle();
        test_stuck_s1();
        test_settle_zero();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
